memory_reader: RTL and testbench
================================

# memory_reader

Read-side counterpart of the memory write driver. On a start command it fetches a programmed number of 32-bit words from the shared 64 x 32 memory through a synchronous read port, starting at a base address. Each word is presented to a downstream consumer over a valid/ready handshake. It sits between the memory array and any block draining stored data.

## Interface
Parameters:
- DW, 32, data word width
- AW, 6, memory address width (depth = 2**AW = 64)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request to begin a read burst; sampled only in IDLE
- base  input  AW  first address of the burst; sampled with start
- count  input  AW+1  number of words to read, 0..64; sampled with start; values >64 clamp to 64
- abort  input  1  synchronous cancel; returns to IDLE
- mem_rd  output  1  memory read enable
- mem_raddr  output  AW  memory read address
- mem_rdata  input  DW  memory read data, valid the cycle after mem_rd
- data_out  output  DW  word presented to consumer
- valid  output  1  data_out holds a valid word
- ready  input  1  consumer accepts data_out when valid&&ready at a rising edge
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last word is accepted
- err  output  1  one-cycle pulse when start arrives with count==0

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: if start&&count==0, pulse err and stay in IDLE. If start&&count!=0, latch ptr=base, remaining=min(count,64), and go to READ.
- READ: mem_rd=1, mem_raddr=ptr. Always go to WAIT.
- WAIT: mem_rd=0. mem_rdata is valid. Register it into data_out at the end of the cycle and go to SEND.
- SEND: valid=1 and data_out is held stable until accepted.
  - On valid&&ready with remaining==1: go to DONE.
  - On valid&&ready with remaining>1: decrement remaining, set ptr=ptr+1 modulo 64, go to READ.
  - Otherwise stay in SEND.
- DONE: done=1 for one cycle, then go to IDLE.
- Address wrap: ptr increments modulo 2**AW, so 63 is followed by 0. A burst of 64 from any base reads every location exactly once.
- abort: has priority over every transition in any non-IDLE state.
  - Next state is IDLE; valid drops the next cycle.
  - done does not pulse. A word in flight is discarded.
  - abort in IDLE has no effect. abort together with start in IDLE: abort wins and no burst starts.
- start while busy is ignored; base and count are not re-sampled.
- Reset (rst low, any time, including mid-burst): immediately force IDLE with these output values:
  - mem_rd=0, mem_raddr=0, data_out=0
  - valid=0, busy=0, done=0, err=0
  - internal ptr=0, remaining=0
- The block never writes memory.

## Timing
- Registered outputs throughout except mem_raddr, which equals ptr.
- Start sampled at edge E0. READ occupies cycle E0..E1 with mem_rd=1. WAIT occupies E1..E2. valid=1 from E2.
- Start-to-first-valid latency is 2 cycles.
- Per-word minimum is 3 cycles: READ, WAIT, and 1 SEND cycle with ready high.
- Back-pressure: while ready is low, valid stays high and data_out, mem_raddr and remaining are frozen. mem_rd stays 0.
- done is asserted the cycle after the final handshake edge. busy falls one cycle later together with the return to IDLE.
- err is asserted the cycle after the start edge; busy stays 0.
- A new start is accepted at the first edge with state==IDLE, which is directly after the DONE cycle.

## Test plan
- Basic burst: memory[i]=32'h1000_0000+i, start with base=4, count=3, ready=1 -> data_out 1000_0004, 1000_0005, 1000_0006 on successive SEND cycles, mem_raddr 4,5,6, done pulses once, first valid 2 cycles after start.
- Wrap-around: base=62, count=4 -> addresses 62, 63, 0, 1 read in order; full burst base=10, count=64 -> 64 words, each address 0..63 exactly once, ends with address 9.
- Back-pressure: count=2, hold ready low for 5 cycles while valid -> data_out stable, valid high, no mem_rd pulses; release ready -> second word follows 3 cycles later.
- Boundary inputs: count=0 -> err pulse, busy stays 0, no mem_rd. count=100 -> exactly 64 words transferred. start while busy -> ignored, burst length unchanged.
- Abort: abort asserted in SEND of word 2 of 5 -> next cycle state IDLE, valid=0, no done pulse; a fresh start afterwards reads from its new base correctly.
- Async reset: drop rst mid-WAIT between clock edges -> all outputs 0 immediately without a clock edge; after release, start with base=0, count=1 -> single correct word and done.

Source files
------------

// File: rtl/memory_reader_if.sv
// Bundle of control, memory-port and consumer-stream signals for memory_reader.
// The master modport is the reader itself; the slave modport is the
// surrounding system (controller, memory array and downstream consumer).
interface memory_reader_if #(
   parameter int DW = 32,
   parameter int AW = 6
);
   // burst control
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   count;
   logic          abort;
   // synchronous memory read port
   logic          mem_rd;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   // downstream valid/ready stream
   logic [DW-1:0] data_out;
   logic          valid;
   logic          ready;
   // status
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      input  start, base, count, abort, mem_rdata, ready,
      output mem_rd, mem_raddr, data_out, valid, busy, done, err
   );

   modport slave (
      output start, base, count, abort, mem_rdata, ready,
      input  mem_rd, mem_raddr, data_out, valid, busy, done, err
   );
endinterface

// File: rtl/memory_reader.sv
// memory_reader: fetches a burst of words from a 2**AW x DW memory through a
// synchronous read port and hands each word to a consumer over valid/ready.
// One word is in flight at a time: READ issues the address, WAIT captures
// the returned data, SEND holds it until the consumer takes it.
module memory_reader #(
   parameter int DW = 32,
   parameter int AW = 6
) (
   input  logic            clk,
   input  logic            rst,
   memory_reader_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      SEND,
      DONE
   } state_t;

   // Largest burst: one pass over the whole memory.
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   remaining_q, remaining_d;
   logic [DW-1:0] data_q;
   logic          load_data;
   logic          err_q, err_d;

   // State register; reset forces IDLE immediately, without a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples pre-edge values regardless of process evaluation order.
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, burst bookkeeping and data-capture decisions.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      load_data   = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Abort arriving with start wins: nothing starts, nothing flags.
            if (bus.start && !bus.abort) begin
               if (bus.count == '0) begin
                  err_d = 1'b1;
               end else begin
                  ptr_d       = bus.base;
                  remaining_d = (bus.count > DEPTH) ? DEPTH : bus.count;
                  state_d     = READ;
               end
            end
         end

         READ: begin
            state_d = WAIT;
         end

         WAIT: begin
            // Read data for the address issued in READ is on mem_rdata now.
            load_data = 1'b1;
            state_d   = SEND;
         end

         SEND: begin
            if (bus.ready) begin
               if (remaining_q == (AW+1)'(1)) begin
                  state_d = DONE;
               end else begin
                  remaining_d = remaining_q - (AW+1)'(1);
                  // Natural AW-bit overflow gives the wrap from top to 0.
                  ptr_d       = ptr_q + AW'(1);
                  state_d     = READ;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides whatever the active state decided; the captured
      // word (if any) is dropped and the pointer/count are left as they were.
      if (bus.abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         ptr_d       = ptr_q;
         remaining_d = remaining_q;
         load_data   = 1'b0;
      end
   end

   // Burst pointer and words-left counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= '0;
         remaining_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
      end
   end

   // Output word register: captured in WAIT, held through back-pressure.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: this datapath register is reset because data_out is a visible
      // output that must read zero during and right after reset.
      if (!rst) begin
         data_q <= '0;
      end else if (load_data) begin
         data_q <= bus.mem_rdata;
      end
   end

   // Zero-count error pulse, one cycle after the offending start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   // Outputs are straight decodes of registered state, so they change only
   // on a clock edge or on reset.
   assign bus.mem_rd    = (state_q == READ);
   assign bus.mem_raddr = ptr_q;
   assign bus.data_out  = data_q;
   assign bus.valid     = (state_q == SEND);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_memory_reader.sv
// Self-checking bench for memory_reader. The stimulus thread pushes the words
// a burst should deliver (address and memory contents) into a queue; a
// separate monitor pops and compares on every valid&&ready handshake.
module tb_memory_reader;

   localparam int DW = 32;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   memory_reader_if #(.DW(DW), .AW(AW)) bus ();

   memory_reader #(.DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Memory model with a one-cycle synchronous read.
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_raddr];
   end

   // Consumer readiness: random or forced by the directed tests.
   bit rdy_rand;
   bit rdy_force;
   bit rnd_bit;
   always @(posedge clk) begin
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
   end
   always_comb bus.ready = rdy_rand ? rnd_bit : rdy_force;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } word_t;

   word_t exp_q[$];
   int checks;
   int errors;
   int done_seen;
   int err_seen;
   int rd_seen;
   int addr_hits[64];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: samples between edges, after stimulus has settled.
   always @(negedge clk) begin
      word_t w;
      #3;
      if (rst) begin
         if (bus.mem_rd) begin
            rd_seen++;
            addr_hits[bus.mem_raddr]++;
         end
         if (bus.done) done_seen++;
         if (bus.err) err_seen++;
         if (bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word actual=%0h required=no_word", bus.data_out);
            end else begin
               w = exp_q.pop_front();
               check("word_data", bus.data_out, w.data);
               check("word_addr", bus.mem_raddr, w.addr);
            end
         end
      end
   end

   // Reference model: a burst delivers min(count,64) consecutive locations
   // starting at base, wrapping modulo 64.
   task automatic push_burst(input int b, input int c);
      word_t w;
      int n;
      n = (c > 64) ? 64 : c;
      for (int i = 0; i < n; i++) begin
         w.addr = AW'((b + i) % 64);
         w.data = mem[(b + i) % 64];
         exp_q.push_back(w);
      end
   endtask

   // Called at a negedge; start is seen by exactly one rising edge.
   task automatic issue_start(input int b, input int c);
      bus.base  = AW'(b);
      bus.count = (AW+1)'(c);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({name, "_idle"}, ok, 1'b1);
   endtask

   task automatic wait_valid(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({name, "_valid"}, ok, 1'b1);
   endtask

   task automatic finish_burst(input string name, input int d0, input int r0, input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done_seen != d0) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_done_seen"}, ok, 1'b1);
      @(negedge clk);
      check({name, "_done_count"}, done_seen - d0, 1);
      check({name, "_reads"}, rd_seen - r0, n);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic run_burst(input string name, input int b, input int c, input bit poke);
      int d0;
      int r0;
      wait_idle(name);
      d0 = done_seen;
      r0 = rd_seen;
      push_burst(b, c);
      issue_start(b, c);
      if (poke) begin
         // A start during the burst must be ignored entirely.
         @(negedge clk);
         bus.base  = AW'($urandom_range(0, 63));
         bus.count = (AW+1)'($urandom_range(1, 127));
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      finish_burst(name, d0, r0, (c > 64) ? 64 : c);
   endtask

   // Hard stop in case something wedges outside a bounded wait.
   initial begin
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int r0;
      int e0;
      int ones;
      int b;
      int c;

      rst       = 1'b0;
      bus.start = 1'b0;
      bus.base  = '0;
      bus.count = '0;
      bus.abort = 1'b0;
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);

      // Reset state
      #12;
      check("rst_mem_rd", bus.mem_rd, 0);
      check("rst_mem_raddr", bus.mem_raddr, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Basic burst with latency checks
      d0 = done_seen;
      r0 = rd_seen;
      push_burst(4, 3);
      issue_start(4, 3);
      check("lat_read_mem_rd", bus.mem_rd, 1);
      check("lat_read_raddr", bus.mem_raddr, 4);
      check("lat_read_valid", bus.valid, 0);
      check("lat_read_busy", bus.busy, 1);
      @(negedge clk);
      check("lat_wait_mem_rd", bus.mem_rd, 0);
      check("lat_wait_valid", bus.valid, 0);
      @(negedge clk);
      check("lat_send_valid", bus.valid, 1);
      check("lat_send_data", bus.data_out, 32'h1000_0004);
      finish_burst("basic", d0, r0, 3);

      // Wrap-around
      run_burst("wrap", 62, 4, 1'b0);

      // Full burst touches every location exactly once
      wait_idle("full_pre");
      for (int i = 0; i < 64; i++) addr_hits[i] = 0;
      run_burst("full", 10, 64, 1'b0);
      ones = 0;
      for (int i = 0; i < 64; i++) if (addr_hits[i] == 1) ones++;
      check("full_each_addr_once", ones, 64);

      // Back-pressure
      wait_idle("bp");
      rdy_force = 1'b0;
      d0 = done_seen;
      r0 = rd_seen;
      push_burst(20, 2);
      issue_start(20, 2);
      wait_valid("bp_first");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", bus.valid, 1);
         check("bp_hold_data", bus.data_out, mem[20]);
      end
      check("bp_no_extra_reads", rd_seen - r0, 1);
      rdy_force = 1'b1;
      @(negedge clk);
      check("bp_rel_valid_1", bus.valid, 0);
      @(negedge clk);
      check("bp_rel_valid_2", bus.valid, 0);
      @(negedge clk);
      check("bp_second_valid", bus.valid, 1);
      check("bp_second_data", bus.data_out, mem[21]);
      finish_burst("bp", d0, r0, 2);

      // count == 0 flags an error and never leaves IDLE
      rdy_rand = 1'b1;
      wait_idle("zero");
      e0 = err_seen;
      r0 = rd_seen;
      issue_start(7, 0);
      check("zero_err_pulse", bus.err, 1);
      check("zero_busy", bus.busy, 0);
      @(negedge clk);
      check("zero_err_single", bus.err, 0);
      check("zero_busy_after", bus.busy, 0);
      check("zero_err_count", err_seen - e0, 1);
      check("zero_no_reads", rd_seen - r0, 0);

      // Oversized count clamps to 64
      run_burst("clamp", 33, 100, 1'b0);

      // Start while busy is ignored
      run_burst("start_busy", 20, 3, 1'b1);

      // Abort during SEND of the second of five words
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      wait_idle("abort");
      d0 = done_seen;
      r0 = rd_seen;
      push_burst(30, 1);
      issue_start(30, 5);
      wait_valid("abort_w1");
      @(negedge clk);
      rdy_force = 1'b0;
      wait_valid("abort_w2");
      check("abort_w2_data", bus.data_out, mem[31]);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_valid", bus.valid, 0);
      check("abort_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
      check("abort_no_done", done_seen - d0, 0);
      check("abort_reads", rd_seen - r0, 2);
      check("abort_drained", exp_q.size(), 0);
      rdy_rand = 1'b1;
      run_burst("after_abort", 50, 2, 1'b0);

      // Asynchronous reset in the middle of WAIT
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      wait_idle("areset");
      issue_start(5, 3);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("areset_mem_rd", bus.mem_rd, 0);
      check("areset_mem_raddr", bus.mem_raddr, 0);
      check("areset_data_out", bus.data_out, 0);
      check("areset_valid", bus.valid, 0);
      check("areset_busy", bus.busy, 0);
      check("areset_done", bus.done, 0);
      check("areset_err", bus.err, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_burst("post_reset", 0, 1, 1'b0);

      // Randomized bursts
      rdy_rand = 1'b1;
      for (int k = 0; k < 25; k++) begin
         wait_idle("rand");
         for (int j = 0; j < 8; j++) mem[$urandom_range(0, 63)] = $urandom;
         b = int'($urandom_range(0, 63));
         c = int'($urandom_range(0, 127));
         if (c == 0) begin
            e0 = err_seen;
            issue_start(b, 0);
            @(negedge clk);
            check("rand_zero_err", err_seen - e0, 1);
         end else begin
            run_burst("rand", b, c, (k % 3) == 0);
         end
      end

      wait_idle("end");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
